serial_nibble_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/fa_step.sv | 13 +
 rtl/serial_nibble_adder.sv | 127 ++++++++++++
 tb/tb_serial_nibble_adder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the serial nibble adder
package serial_adder_pkg;

    localparam int N_BITS = 4;
    localparam int CNT_W  = 2;

    localparam int CLK_PIN   = 0;
    localparam int RST_PIN   = 1;
    localparam int VALID_PIN = 2;
    localparam int MODE_PIN  = 3;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        ADD    = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/fa_step.sv
// rtl/fa_step.sv - combinational 1-bit full adder matching the existing tile
module fa_step (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_nibble_adder.sv
// rtl/serial_nibble_adder.sv - bit-serial 4-bit add/subtract front-end for one 8-in/8-out slot
// Optional SERIAL_ADDER_OVERFLOW_EN: io_out[7] shows signed overflow in DONE.
module serial_nibble_adder
    import serial_adder_pkg::*;
(
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic w_clk;
    logic w_rst;
    logic w_valid;
    logic w_mode;
    logic [N_BITS-1:0] w_data;

    assign w_clk   = io_in[CLK_PIN];
    assign w_rst   = io_in[RST_PIN];
    assign w_valid = io_in[VALID_PIN];
    assign w_mode  = io_in[MODE_PIN];
    assign w_data  = io_in[7:4];

    state_t            r_state;
    logic [N_BITS-1:0] r_a;
    logic [N_BITS-1:0] r_b;
    logic [N_BITS-1:0] r_result;
    logic              r_carry;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mode;
    logic              r_valid_prev;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic              r_c_msb;
`endif

    logic w_strobe;
    logic w_last;
    logic w_a_bit;
    logic w_b_bit;
    logic w_cin;
    logic w_s;
    logic w_cout;

    assign w_strobe = w_valid & ~r_valid_prev;
    assign w_last   = (r_cnt == CNT_W'(N_BITS - 1));
    assign w_a_bit  = r_a[r_cnt];
    assign w_b_bit  = r_b[r_cnt];
    // The first step takes its carry-in straight from the latched mode (+1 of two's complement).
    assign w_cin    = (r_cnt == '0) ? r_mode : r_carry;

    fa_step u_fa_step (
        .i_a    (w_a_bit),
        .i_b    (w_b_bit),
        .i_cin  (w_cin),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_carry      <= 1'b0;
            r_cnt        <= '0;
            r_mode       <= MODE_ADD;
            r_valid_prev <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            r_c_msb      <= 1'b0;
`endif
        end else begin
            r_valid_prev <= w_valid;
            case (r_state)
                IDLE, DONE: begin
                    if (w_strobe) begin
                        r_a     <= w_data;
                        r_state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (w_strobe) begin
                        r_b      <= (w_mode == MODE_SUB) ? ~w_data : w_data;
                        r_mode   <= w_mode;
                        r_carry  <= w_mode;
                        r_cnt    <= '0;
                        r_result <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        r_c_msb  <= 1'b0;
`endif
                        r_state  <= ADD;
                    end
                end
                ADD: begin
                    r_result[r_cnt] <= w_s;
                    r_carry         <= w_cout;
                    r_cnt           <= r_cnt + 1'b1;
                    if (w_last) begin
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        r_c_msb <= w_cin;
`endif
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic w_bit7;
    always_comb begin
        w_bit7 = 1'b0;
        if (r_state == ADD) begin
            w_bit7 = w_s;
        end
`ifdef SERIAL_ADDER_OVERFLOW_EN
        else if (r_state == DONE) begin
            w_bit7 = r_c_msb ^ r_carry;
        end
`endif
    end

    assign io_out[3:0] = r_result;
    assign io_out[4]   = r_carry;
    assign io_out[5]   = (r_state == ADD);
    assign io_out[6]   = (r_state == DONE);
    assign io_out[7]   = w_bit7;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// tb/tb_serial_nibble_adder.sv - self-checking bench for serial_nibble_adder
module tb_serial_nibble_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] data = 4'd0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int n_tests = 0;
    int n_fail  = 0;

    assign io_in = {data, mode, valid, rst, clk};

    serial_nibble_adder dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       m;
        logic [3:0] r;
        logic       c;
        logic       ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model(input int a, input int b, input int m,
                                  output int r, output int c, output int ov);
        int sa, sb, st;
        r  = (m != 0) ? ((a - b) & 15) : ((a + b) & 15);
        c  = (m != 0) ? int'(a >= b) : int'(a + b >= 16);
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        st = (m != 0) ? sa - sb : sa + sb;
        ov = int'(st < -8 || st > 7);
    endfunction

    task automatic strobe(input logic [3:0] d, input logic m);
        @(negedge clk);
        valid = 1'b1;
        data  = d;
        mode  = m;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Runs the ADD phase from the negedge right after the B strobe, then checks DONE outputs.
    task automatic finish_and_check(input string tag, input logic [3:0] er, input logic ec,
                                    input logic eov, input logic jam);
        logic [3:0] ser;
        int nb;
        ser = 4'd0;
        nb  = 0;
        for (int k = 0; k < 12; k++) begin
            if (io_out[6]) break;
            if (io_out[5]) begin
                if (nb < 4) ser[nb] = io_out[7];
                nb++;
            end
            if (jam) begin
                valid = ~valid;
                data  = 4'hF;
                mode  = 1'b1;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        check({tag, " done"}, io_out[6], 1);
        check({tag, " busy_cycles"}, nb, 4);
        check({tag, " result"}, io_out[3:0], er);
        check({tag, " carry"}, io_out[4], ec);
        check({tag, " serial"}, ser, er);
        check({tag, " busy_in_done"}, io_out[5], 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check({tag, " bit7_done"}, io_out[7], eov);
`else
        check({tag, " bit7_done"}, io_out[7], 0);
        if (eov === 1'bx) $display("unexpected x");
`endif
    endtask

    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic m, input logic [3:0] er, input logic ec, input logic eov);
        strobe(a, 1'b0);
        check({tag, " done_cleared"}, io_out[6], 0);
        strobe(b, m);
        finish_and_check(tag, er, ec, eov, 1'b0);
    endtask

    vec_t vecs[8];

    initial begin
        int r, c, ov;
        vecs[0] = '{a: 4'd5,  b: 4'd3,  m: 1'b0, r: 4'd8,  c: 1'b0, ov: 1'b1};
        vecs[1] = '{a: 4'd9,  b: 4'd9,  m: 1'b0, r: 4'd2,  c: 1'b1, ov: 1'b1};
        vecs[2] = '{a: 4'd3,  b: 4'd5,  m: 1'b1, r: 4'd14, c: 1'b0, ov: 1'b0};
        vecs[3] = '{a: 4'd7,  b: 4'd2,  m: 1'b1, r: 4'd5,  c: 1'b1, ov: 1'b0};
        vecs[4] = '{a: 4'd7,  b: 4'd1,  m: 1'b0, r: 4'd8,  c: 1'b0, ov: 1'b1};
        vecs[5] = '{a: 4'd2,  b: 4'd3,  m: 1'b0, r: 4'd5,  c: 1'b0, ov: 1'b0};
        vecs[6] = '{a: 4'd0,  b: 4'd0,  m: 1'b1, r: 4'd0,  c: 1'b1, ov: 1'b0};
        vecs[7] = '{a: 4'd15, b: 4'd15, m: 1'b0, r: 4'd14, c: 1'b1, ov: 1'b0};

        #1 rst = 1'b1;
        #1 check("reset_async", io_out, 8'h00);
        repeat (3) @(negedge clk);
        check("reset_held", io_out, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].m,
                   vecs[i].r, vecs[i].c, vecs[i].ov);
        end

        // Valid held high: one strobe only, so the block waits in LOAD_B.
        @(negedge clk);
        valid = 1'b1;
        data  = 4'd3;
        mode  = 1'b0;
        repeat (10) @(negedge clk);
        check("held_valid busy", io_out[5], 0);
        check("held_valid done", io_out[6], 0);
        valid = 1'b0;
        strobe(4'd4, 1'b0);
        finish_and_check("held_valid op", 4'd7, 1'b0, 1'b0, 1'b0);

        // Strobes toggled throughout ADD are ignored.
        strobe(4'd5, 1'b0);
        strobe(4'd3, 1'b0);
        finish_and_check("jam", 4'd8, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("jam stays_done", io_out[6], 1);

        // Reset on the second ADD cycle aborts immediately.
        strobe(4'd9, 1'b0);
        strobe(4'd9, 1'b0);
        @(negedge clk);
        check("midreset busy_before", io_out[5], 1);
        #2 rst = 1'b1;
        #1 check("midreset outputs", io_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_reset", 4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] a, b;
            logic m;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            m = 1'($urandom_range(0, 1));
            model(int'(a), int'(b), int'(m), r, c, ov);
            run_op($sformatf("rnd%0d a=%0d b=%0d m=%0d", i, a, b, m), a, b, m,
                   4'(r), 1'(c), 1'(ov));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
